// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator. One prescaled period counter (edge- or center-aligned)
// drives CHANNELS comparators, each with a double-buffered duty value.
module pwm_multi_channel #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int PRESCALE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      duty_load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      load_pending
);

  localparam logic [WIDTH-1:0] TOP    = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] TOP_M1 = TOP - 1'b1;
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  dir_e                  dir_q, dir_d;
  logic                  mode_act_q, mode_act_d;
  logic [WIDTH-1:0]      shadow_q [CHANNELS];
  logic [WIDTH-1:0]      shadow_d [CHANNELS];
  logic [WIDTH-1:0]      active_q [CHANNELS];
  logic [WIDTH-1:0]      active_d [CHANNELS];
  logic                  load_pending_q, load_pending_d;
  logic [CHANNELS-1:0]   pwm_out_q, pwm_out_d;
  logic                  period_start_q, period_start_d;
  logic                  tick;
  logic                  boundary;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    pre_cnt_d      = pre_cnt_q;
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    mode_act_d     = mode_act_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    load_pending_d = load_pending_q;
    boundary       = 1'b0;
    tick           = en && (pre_cnt_q >= prescale);

    if (en) pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

    if (tick) begin
      if (!mode_act_q) begin
        if (cnt_q == TOP) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (dir_q == DIR_UP) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TOP_M1) dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ONE) begin
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end
      end
    end

    // Commit reads the shadow before any same-cycle load overwrites it.
    if (boundary) begin
      mode_act_d = mode;
      if (mode != mode_act_q) dir_d = DIR_UP;
      if (load_pending_q) begin
        active_d       = shadow_q;
        load_pending_d = 1'b0;
      end
    end

    if (duty_load) begin
      for (int i = 0; i < CHANNELS; i++) shadow_d[i] = duty[i*WIDTH +: WIDTH];
      load_pending_d = 1'b1;
    end

    period_start_d = boundary;
    for (int i = 0; i < CHANNELS; i++) pwm_out_d[i] = en && (cnt_q < active_q[i]);
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      mode_act_q     <= 1'b0;
      shadow_q       <= '{default: '0};
      active_q       <= '{default: '0};
      load_pending_q <= 1'b0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_act_q     <= mode_act_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      load_pending_q <= load_pending_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign load_pending = load_pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: a period-position reference model feeds a per-cycle
// expectation queue; a monitor pops and compares, while directed tasks measure whole periods.
module tb_pwm_multi_channel;
  localparam int WIDTH = 4;
  localparam int CH    = 2;
  localparam int PW    = 16;
  localparam int TOP   = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              mode = 1'b0;
  logic [PW-1:0]     prescale = '0;
  logic [CH*WIDTH-1:0] duty = '0;
  logic              duty_load = 1'b0;
  logic [CH-1:0]     pwm_out;
  logic              period_start;
  logic              load_pending;

  int checks = 0;
  int errors = 0;

  pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .prescale     (prescale),
    .duty         (duty),
    .duty_load    (duty_load),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: position within the period, counter value derived arithmetically.
  int        m_pre, m_pos;
  bit        m_mode, m_pend;
  int        m_shadow [CH];
  int        m_active [CH];
  logic [3:0] exp_q [$];

  function automatic int mcnt(int p, bit m);
    if (!m) return p;
    return (p <= TOP) ? p : 2*TOP - p;
  endfunction

  initial begin : model
    logic [CH-1:0] ep;
    bit eb, tk;
    int c, len;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pre = 0; m_pos = 0; m_mode = 0; m_pend = 0;
        for (int i = 0; i < CH; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
        exp_q.push_back(4'b0000);
      end else begin
        c = mcnt(m_pos, m_mode);
        for (int i = 0; i < CH; i++) ep[i] = en && (c < m_active[i]);
        tk = en && (m_pre >= int'(prescale));
        if (en) m_pre = tk ? 0 : m_pre + 1;
        len = m_mode ? 2*TOP : TOP + 1;
        eb = 0;
        if (tk) begin
          m_pos++;
          if (m_pos == len) begin m_pos = 0; eb = 1; end
        end
        if (eb) begin
          m_mode = mode;
          if (m_pend) begin
            for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
            m_pend = 0;
          end
        end
        if (duty_load) begin
          for (int i = 0; i < CH; i++) m_shadow[i] = int'(duty[i*WIDTH +: WIDTH]);
          m_pend = 1;
        end
        exp_q.push_back({m_pend, eb, ep});
      end
    end
  end

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle{pend,ps,pwm}", {28'b0, load_pending, period_start, pwm_out}, {28'b0, e});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int d1, input int d0);
    duty      = {WIDTH'(d1), WIDTH'(d0)};
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    step();
    while (period_start !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("period_start_timeout", {31'b0, period_start}, 1);
  endtask

  task automatic measure(input string name, input int exp_len, input int exp_h0, input int exp_h1);
    int len = 0, h0 = 0, h1 = 0;
    wait_ps();
    do begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      len++;
      step();
    end while (period_start !== 1'b1 && len < 400);
    check({name, "_len"}, len, exp_len);
    check({name, "_hi0"}, h0, exp_h0);
    check({name, "_hi1"}, h1, exp_h1);
  endtask

  initial begin : driver
    step(3);
    check("reset_outputs", {29'b0, load_pending, period_start, pwm_out}, 0);
    rst = 1'b0;

    // Edge mode, duty {5,3}
    en = 1'b1;
    load(5, 3);
    measure("s1_p1", 15, 3, 5);
    measure("s1_p2", 15, 3, 5);

    // Extremes, then disable
    load(15, 0);
    wait_ps();
    repeat (3) measure("s2", 15, 0, 15);
    en = 1'b0;
    step();
    check("s2_en_off_pwm", {30'b0, pwm_out}, 0);
    step(6);
    en = 1'b1;
    step(20);

    // Double buffer
    load(0, 3);
    wait_ps();
    step(4);
    load(0, 10);
    step(3);
    load(0, 7);
    wait_ps();
    measure("s3_next", 15, 7, 0);
    step(14);
    duty      = {WIDTH'(0), WIDTH'(9)};
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
    check("s3_boundary_ps", {31'b0, period_start}, 1);
    check("s3_boundary_pend", {31'b0, load_pending}, 1);
    wait_ps();
    measure("s3_late", 15, 9, 0);

    // Center mode
    mode = 1'b1;
    load(0, 4);
    wait_ps();
    measure("s4", 28, 7, 0);

    // Prescaler
    mode     = 1'b0;
    prescale = 16'd2;
    load(0, 5);
    wait_ps();
    measure("s5", 45, 15, 0);
    step(4);
    prescale = '0;
    step(20);

    // Reset with a pending load
    load(0, 2);
    step(2);
    check("s6_pending_before", {31'b0, load_pending}, 1);
    rst = 1'b1;
    step();
    check("s6_reset", {29'b0, load_pending, period_start, pwm_out}, 0);
    rst = 1'b0;
    step(20);
    check("s6_discarded", {29'b0, load_pending, 1'b0, pwm_out}, 0);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      en        = ($urandom % 10) != 0;
      duty_load = ($urandom % 8) == 0;
      duty      = CH*WIDTH'($urandom);
      if ($urandom % 20 == 0) mode = 1'($urandom % 2);
      if ($urandom % 30 == 0) prescale = PW'($urandom % 3);
      rst = ($urandom % 250) == 0;
      step();
    end
    rst       = 1'b0;
    duty_load = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
